prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_pkg.sv | 16 +
 rtl/prbs_sat_cnt.sv | 27 ++
 rtl/prbs_checker.sv | 126 ++++++++++++
 tb/tb_prbs_checker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types and helpers for the 4-bit PRBS checker.
// Holds the lock FSM states, reset seed and LFSR step function.
package prbs_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [3:0] PRBS_SEED = 4'hF;

   function automatic logic [3:0] lfsr4_next(input logic [3:0] s);
      return {s[2:0], s[3] ^ s[2]};
   endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with clear taking priority over increment.
// Used as the PRBS checker error counter.
module prbs_sat_cnt #(
   parameter int ERR_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [ERR_W-1:0] o_cnt
);

   logic [ERR_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {ERR_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/prbs_checker.sv
// 4-bit PRBS checker: hunts for LFSR alignment, then counts word errors.
// Optional all-zero-word alarm enabled by macro PRBS_CHK_ZERO_DET_EN.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [3:0]       data_i,
   input  logic             valid_i,
   input  logic             clr_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic             zero_o
);

   localparam logic [3:0] LOCK_M1 = 4'(LOCK_CNT - 1);
   localparam logic [3:0] LOSS_M1 = 4'(LOSS_CNT - 1);

   state_t     r_state;
   logic [3:0] r_ref;
   logic [3:0] r_match;
   logic [3:0] r_miss;
   logic       r_seeded;
   logic       r_locked;
   logic       r_err;

   logic [3:0] w_exp;
   logic       w_hit;
   logic       w_zero;
   logic       w_err;

   assign w_exp = lfsr4_next(r_ref);
   assign w_hit = (data_i == w_exp);
   assign w_err = valid_i && (r_state == LOCKED) && !w_hit;

`ifdef PRBS_CHK_ZERO_DET_EN
   logic r_zero;

   assign w_zero = (data_i == 4'h0);

   always_ff @(posedge clk) begin
      if (RST) begin
         r_zero <= 1'b0;
      end else if (valid_i && w_zero) begin
         r_zero <= 1'b1;
      end else if (clr_i) begin
         r_zero <= 1'b0;
      end
   end

   assign zero_o = r_zero;
`else
   assign w_zero = 1'b0;
   assign zero_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (RST) begin
         r_state  <= HUNT;
         r_ref    <= PRBS_SEED;
         r_match  <= '0;
         r_miss   <= '0;
         r_seeded <= 1'b0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_err <= w_err;
         if (valid_i) begin
            unique case (r_state)
               HUNT: begin
                  r_ref    <= data_i;
                  r_seeded <= 1'b1;
                  // The seeding word has no predecessor to match against.
                  if (r_seeded && w_hit && !w_zero) begin
                     if (r_match == LOCK_M1) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                        r_match  <= '0;
                     end else begin
                        r_match <= r_match + 1'b1;
                     end
                  end else begin
                     r_match <= '0;
                  end
               end
               LOCKED: begin
                  r_ref <= w_exp;
                  if (!w_hit) begin
                     if (r_miss == LOSS_M1) begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                        r_miss   <= '0;
                        r_match  <= '0;
                        r_seeded <= 1'b0;
                     end else begin
                        r_miss <= r_miss + 1'b1;
                     end
                  end else begin
                     r_miss <= '0;
                  end
               end
               default: r_state <= HUNT;
            endcase
         end
      end
   end

   prbs_sat_cnt #(
      .ERR_W (ERR_W)
   ) u_cnt (
      .clk   (clk),
      .rst   (RST),
      .i_inc (w_err),
      .i_clr (clr_i),
      .o_cnt (err_cnt_o)
   );

   assign locked_o = r_locked;
   assign err_o    = r_err;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker (ERR_W=16 and ERR_W=2 instances).
// Define PRBS_CHK_ZERO_DET_EN to exercise the zero-word alarm build.
module tb_prbs_checker;

   localparam int LOCK_CNT = 4;
   localparam int LOSS_CNT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  data;
   logic        valid;
   logic        clr;

   logic        locked, err, zero;
   logic [15:0] cnt;
   logic        locked2, err2, zero2;
   logic [1:0]  cnt2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   prbs_checker #(
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT),
      .ERR_W    (16)
   ) u_dut (
      .clk       (clk),
      .RST       (rst),
      .data_i    (data),
      .valid_i   (valid),
      .clr_i     (clr),
      .locked_o  (locked),
      .err_o     (err),
      .err_cnt_o (cnt),
      .zero_o    (zero)
   );

   prbs_checker #(
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT),
      .ERR_W    (2)
   ) u_dut2 (
      .clk       (clk),
      .RST       (rst),
      .data_i    (data),
      .valid_i   (valid),
      .clr_i     (clr),
      .locked_o  (locked2),
      .err_o     (err2),
      .err_cnt_o (cnt2),
      .zero_o    (zero2)
   );

   // Reference sequence of the 4-bit maximal-length LFSR.
   int seq [15] = '{15, 14, 12, 8, 1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7};

   function automatic int tnext(input int x);
      for (int i = 0; i < 15; i++)
         if (seq[i] == x) return seq[(i + 1) % 15];
      return 0;
   endfunction

   function automatic bit link(input int a, input int b);
`ifdef PRBS_CHK_ZERO_DET_EN
      if (b == 0) return 1'b0;
`endif
      return tnext(a) == b;
   endfunction

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", n, act, exp, $time);
      end
   endtask

   // Behavioural model: hunt history chain length, table-walk when locked.
   bit m_live = 0;
   int m_lock, m_err, m_cnt16, m_cnt2, m_zero, m_miss, m_ref;
   int hist[$];

   always @(posedge clk) begin
      int run, e;
      if (rst) begin
         m_live = 1; m_lock = 0; m_err = 0; m_cnt16 = 0; m_cnt2 = 0;
         m_zero = 0; m_miss = 0; m_ref = 15;
         hist.delete();
      end else begin
         m_err = 0;
         if (valid) begin
`ifdef PRBS_CHK_ZERO_DET_EN
            if (data == 4'h0) m_zero = 1;
`endif
            if (m_lock == 0) begin
               hist.push_back(int'(data));
               run = 1;
               for (int i = hist.size() - 1; i > 0; i--) begin
                  if (link(hist[i-1], hist[i])) run++;
                  else break;
               end
               if (run >= LOCK_CNT + 1) begin
                  m_lock = 1;
                  m_ref  = int'(data);
               end
            end else begin
               e = tnext(m_ref);
               m_ref = e;
               if (int'(data) != e) begin
                  m_err = 1;
                  if (m_cnt16 < 65535) m_cnt16++;
                  if (m_cnt2 < 3) m_cnt2++;
                  m_miss++;
                  if (m_miss == LOSS_CNT) begin
                     m_lock = 0; m_miss = 0;
                     hist.delete();
                  end
               end else begin
                  m_miss = 0;
               end
            end
         end
         if (clr) begin
            m_cnt16 = 0; m_cnt2 = 0;
            if (!(valid && data == 4'h0)) m_zero = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("locked", locked, m_lock);
         chk("err", err, m_err);
         chk("cnt16", cnt, m_cnt16);
         chk("zero", zero, m_zero);
         chk("locked2", locked2, m_lock);
         chk("err2", err2, m_err);
         chk("cnt2", cnt2, m_cnt2);
         chk("zero2", zero2, m_zero);
      end
   end

   task automatic drive(input logic v, input logic [3:0] d, input logic c);
      valid = v; data = d; clr = c;
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] d);
      drive(1'b1, d, 1'b0);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; data = 4'h0; clr = 1'b0;
      @(negedge clk);
      drive(1'b0, 4'h0, 1'b0);
      rst = 1'b0;
      chk("rst_locked", locked, 0);
      chk("rst_err", err, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_zero", zero, 0);

      send(4'hF); send(4'hE); send(4'hC); send(4'h8);
      chk("pre_lock", locked, 0);
      send(4'h1);
      chk("lock_after_1", locked, 1);
      chk("lock_cnt0", cnt, 0);

      send(4'h2); send(4'h4); send(4'h7);
      chk("single_err", err, 1);
      chk("single_cnt", cnt, 1);
      chk("single_locked", locked, 1);
      send(4'h3);
      chk("after_err_clean", err, 0);
      chk("after_err_locked", locked, 1);

      send(4'h6); send(4'hD);
      send(4'h1); send(4'h1);
      chk("two_miss_locked", locked, 1);
      chk("two_miss_cnt", cnt, 3);
      send(4'h1);
      chk("loss_err", err, 1);
      chk("loss_locked", locked, 0);
      chk("loss_cnt16", cnt, 4);
      chk("loss_cnt2_sat", cnt2, 3);

      send(4'h7); send(4'hF); send(4'hE); send(4'hC);
      chk("relock_pre", locked, 0);
      send(4'h8);
      chk("relock", locked, 1);

      drive(1'b0, 4'h0, 1'b1);
      chk("clr_idle", cnt, 0);

      send(4'hF);
      chk("w2_e1", cnt2, 1);
      send(4'h2); send(4'hF);
      chk("w2_e2", cnt2, 2);
      send(4'h9); send(4'hF);
      chk("w2_e3", cnt2, 3);
      send(4'h6);
      drive(1'b1, 4'hF, 1'b1);
      chk("w2_clr_wins", cnt2, 0);
      chk("w2_clr_err", err2, 1);
      send(4'hA); send(4'hF);
      chk("w2_e5", cnt2, 1);
      send(4'hB);
      send(4'hF); send(4'hF); send(4'hF); send(4'hC); send(4'hF);
      chk("w2_sat", cnt2, 3);
      chk("w16_cnt", cnt, 4);
      chk("w_still_locked", locked, 1);

      rst = 1'b1;
      drive(1'b1, 4'h1, 1'b1);
      rst = 1'b0;
      chk("midrst_locked", locked, 0);
      chk("midrst_cnt", cnt, 0);

      send(4'hF); drive(1'b0, 4'h5, 1'b0);
      send(4'hE); drive(1'b0, 4'h3, 1'b0);
      send(4'hC); drive(1'b0, 4'h0, 1'b0);
      send(4'h8); drive(1'b0, 4'h7, 1'b0);
      chk("tog_pre", locked, 0);
      send(4'h1);
      chk("tog_lock", locked, 1);
      drive(1'b0, 4'h9, 1'b0);
      chk("tog_hold", locked, 1);
      chk("tog_idle_err", err, 0);

      rst = 1'b1;
      drive(1'b0, 4'h0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) send(4'h0);
`ifdef PRBS_CHK_ZERO_DET_EN
      chk("zero5_locked", locked, 0);
      chk("zero5_alarm", zero, 1);
`else
      chk("zero5_locked", locked, 1);
      chk("zero5_alarm", zero, 0);
`endif
      for (int i = 0; i < 3; i++) send(4'h0);
`ifdef PRBS_CHK_ZERO_DET_EN
      chk("zero8_locked", locked, 0);
      chk("zero8_alarm", zero, 1);
`else
      chk("zero8_locked", locked, 1);
      chk("zero8_alarm", zero, 0);
`endif
      drive(1'b0, 4'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
